// File: rtl/full_adder_pkg.sv
// Shared definitions for the ripple-carry full adder: default width,
// the {carryout, sum} result record and the single-bit add function.
package full_adder_pkg;

  // Width used when an instance does not override WIDTH.
  localparam int DEFAULT_WIDTH = 1;

  // Result record for a default-width adder; carryout sits above sum so the
  // packed value equals the arithmetic a + b + carry.
  typedef struct packed {
    logic                     carryout;
    logic [DEFAULT_WIDTH-1:0] sum;
  } fa_result_t;

  // One-bit full add. Returns {carry_out, sum_bit}.
  function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic cin);
    logic s_s;
    logic c_s;
    s_s = a ^ b ^ cin;
    c_s = (a & b) | (cin & (a ^ b));
    return {c_s, s_s};
  endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder cell: one stage of the ripple chain.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic [1:0] add_s;

  // Pure combinational add; settles in the same timestep as any input change.
  always_comb begin
    add_s = fa_bit(a, b, cin);
  end

  assign s    = add_s[0];
  assign cout = add_s[1];

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// Parameterisable ripple-carry adder with a combinational result and a
// one-cycle registered copy qualified by a valid strobe.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic [WIDTH-1:0] sum_q,
  output logic             carryout_q,
  output logic             out_valid
);

  // Result record at this instance's width; carryout is the MSB so the
  // packed value is the full WIDTH+1 bit sum.
  typedef struct packed {
    logic             carryout;
    logic [WIDTH-1:0] sum;
  } result_t;

  // Carry chain: c_s[0] is the external carry-in, c_s[WIDTH] the carry-out.
  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] sum_s;
  result_t          result_s;
  result_t          result_r;
  logic             valid_r;

  assign c_s[0] = carry;

  // Ripple structure: cell i consumes c_s[i] and produces c_s[i+1].
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_adder_cell u_cell (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (c_s[gi]),
        .s    (sum_s[gi]),
        .cout (c_s[gi+1])
      );
    end
  endgenerate

  // Pack the combinational result for the register stage.
  always_comb begin
    result_s.sum      = sum_s;
    result_s.carryout = c_s[WIDTH];
  end

  assign sum      = result_s.sum;
  assign carryout = result_s.carryout;

  // Output register: capture on accepted input, hold otherwise; the valid
  // strobe follows in_valid by exactly one cycle. Reset drops any pending
  // result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= '{carryout: 1'b0, sum: {WIDTH{1'b0}}};
      valid_r  <= 1'b0;
    end else begin
      valid_r <= in_valid;
      if (in_valid) begin
        result_r <= result_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign sum_q      = result_r.sum;
  assign carryout_q = result_r.carryout;
  assign out_valid  = valid_r;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed and table-driven bench for full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk;
  logic rst_n;

  // WIDTH=1 instance signals
  logic a1, b1, c1, v1;
  logic s1, co1, sq1, coq1, ov1;

  // WIDTH=4 instance signals
  logic [3:0] a4, b4;
  logic       c4, v4;
  logic [3:0] s4, sq4;
  logic       co4, coq4, ov4;

  int checks;
  int errors;

  typedef struct {
    logic       a;
    logic       b;
    logic       c;
    fa_result_t exp;
  } vec1_t;

  vec1_t vecs1[8];

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .carry(c1), .in_valid(v1),
    .sum(s1), .carryout(co1), .sum_q(sq1), .carryout_q(coq1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .carry(c4), .in_valid(v4),
    .sum(s4), .carryout(co4), .sum_q(sq4), .carryout_q(coq4), .out_valid(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin : main
    logic [4:0] exp4;
    logic [4:0] held4;
    checks = 0;
    errors = 0;

    // Truth table, hand-written: {a,b,c} -> {carryout,sum}
    vecs1[0] = '{1'b0, 1'b0, 1'b0, '{carryout: 1'b0, sum: 1'b0}};
    vecs1[1] = '{1'b0, 1'b1, 1'b0, '{carryout: 1'b0, sum: 1'b1}};
    vecs1[2] = '{1'b1, 1'b0, 1'b0, '{carryout: 1'b0, sum: 1'b1}};
    vecs1[3] = '{1'b1, 1'b1, 1'b0, '{carryout: 1'b1, sum: 1'b0}};
    vecs1[4] = '{1'b0, 1'b0, 1'b1, '{carryout: 1'b0, sum: 1'b1}};
    vecs1[5] = '{1'b0, 1'b1, 1'b1, '{carryout: 1'b1, sum: 1'b0}};
    vecs1[6] = '{1'b1, 1'b0, 1'b1, '{carryout: 1'b1, sum: 1'b0}};
    vecs1[7] = '{1'b1, 1'b1, 1'b1, '{carryout: 1'b1, sum: 1'b1}};

    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; c4 = 1'b0; v4 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_sum_q", {31'd0, sq1}, 32'd0);
    check("reset_carryout_q", {31'd0, coq1}, 32'd0);
    check("reset_out_valid", {31'd0, ov1}, 32'd0);
    check("reset_out_valid_w4", {31'd0, ov4}, 32'd0);

    // WIDTH=1 exhaustive, each combination held 10 ns
    for (int i = 0; i < 8; i++) begin
      a1 = vecs1[i].a; b1 = vecs1[i].b; c1 = vecs1[i].c;
      #10;
      check($sformatf("tt_sum_%0d", i), {31'd0, s1}, {31'd0, vecs1[i].exp.sum});
      check($sformatf("tt_co_%0d", i), {31'd0, co1}, {31'd0, vecs1[i].exp.carryout});
    end

    // Zero-latency tracking: 101, 111, 101
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; #1;
    check("track1", {30'd0, co1, s1}, 32'd2);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; #1;
    check("track2", {30'd0, co1, s1}, 32'd3);
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; #1;
    check("track3", {30'd0, co1, s1}, 32'd2);

    // Release reset; registered capture of 110
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    check("reg_capture", {29'd0, ov1, coq1, sq1}, 32'd6);
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    @(posedge clk); #1;
    check("reg_hold", {29'd0, ov1, coq1, sq1}, 32'd2);

    // Capture 111, then async reset mid-cycle
    @(negedge clk);
    v1 = 1'b1;
    @(posedge clk); #1;
    check("reg_capture_111", {29'd0, ov1, coq1, sq1}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {29'd0, ov1, coq1, sq1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    check("post_reset_capture", {29'd0, ov1, coq1, sq1}, 32'd6);
    @(negedge clk);
    v1 = 1'b0;

    // WIDTH=4 wrap-around
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1; #1;
    check("w4_wrap_f01", {27'd0, co4, s4}, 32'h10);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; #1;
    check("w4_wrap_ff1", {27'd0, co4, s4}, 32'h1F);
    a4 = 4'h7; b4 = 4'h8; c4 = 1'b0; #1;
    check("w4_no_carry", {27'd0, co4, s4}, 32'h0F);

    // WIDTH=4 random: combinational and registered against a model
    held4 = 5'd0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a4 = 4'($urandom_range(15, 0));
      b4 = 4'($urandom_range(15, 0));
      c4 = 1'($urandom_range(1, 0));
      v4 = 1'($urandom_range(1, 0));
      exp4 = {1'b0, a4} + {1'b0, b4} + {4'd0, c4};
      #1;
      check("w4_rand_comb", {27'd0, co4, s4}, {27'd0, exp4});
      if (v4) held4 = exp4;
      @(posedge clk); #1;
      check("w4_rand_reg", {26'd0, ov4, coq4, sq4}, {26'd0, v4, held4});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_full_adder
